// File: rtl/mips_run_controller.sv
// Load/run/dump sequencer wrapped around the single-cycle MIPS core: streams a program
// into instruction memory, runs the core for a bounded number of cycles, then dumps the register file.
module mips_run_controller #(
    parameter int INST_WIDTH     = 32,
    parameter int PC_WIDTH       = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int NUM_REGS       = 16,
    parameter int CYCLE_WIDTH    = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [INST_WIDTH-1:0]     load_data,
    input  logic                      load_last,
    output logic                      imem_we,
    output logic [PC_WIDTH-1:0]       imem_addr,
    output logic [INST_WIDTH-1:0]     imem_wdata,
    input  logic                      start,
    input  logic                      clear,
    input  logic [CYCLE_WIDTH-1:0]    max_cycles,
    input  logic [PC_WIDTH-1:0]       halt_pc,
    input  logic                      halt_pc_en,
    input  logic [PC_WIDTH-1:0]       cpu_pc,
    output logic                      cpu_run,
    output logic                      cpu_rst_n,
    output logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic [DATA_WIDTH-1:0]     reg_rd_data,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic [DATA_WIDTH-1:0]     dump_data,
    output logic [REG_ADDR_WIDTH-1:0] dump_idx,
    output logic                      dump_last,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                halt_cause,
    output logic [CYCLE_WIDTH-1:0]    cycles_run
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DUMP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [PC_WIDTH-1:0]       ADDR_MAX = {PC_WIDTH{1'b1}};
    localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(NUM_REGS - 1);

    state_t                    state_r;
    state_t                    state_next_s;
    logic [PC_WIDTH-1:0]       wr_addr_r;
    logic [PC_WIDTH-1:0]       cur_addr_s;
    logic [CYCLE_WIDTH-1:0]    max_cycles_r;
    logic [CYCLE_WIDTH-1:0]    cycles_run_r;
    logic [PC_WIDTH-1:0]       halt_pc_r;
    logic                      halt_pc_en_r;
    logic [1:0]                halt_cause_r;
    logic [REG_ADDR_WIDTH-1:0] dump_idx_r;
    logic                      load_ready_s;
    logic                      beat_s;
    logic                      overflow_s;
    logic                      start_s;
    logic                      pc_match_s;
    logic                      run_s;
    logic                      limit_s;
    logic                      dump_last_s;
    logic                      dump_hs_s;

    // Handshake qualifiers; beats are masked by reset so the write strobe drops without a clock
    always_comb begin
        load_ready_s = (state_r == ST_IDLE) || (state_r == ST_LOAD);
        beat_s       = load_valid && load_ready_s && reset_n;
        cur_addr_s   = (state_r == ST_IDLE) ? {PC_WIDTH{1'b0}} : wr_addr_r;
        overflow_s   = beat_s && !load_last && (cur_addr_s == ADDR_MAX);
        start_s      = (state_r == ST_IDLE) && start && !beat_s;
        pc_match_s   = halt_pc_en_r && (cpu_pc == halt_pc_r);
        run_s        = (state_r == ST_RUN) && !pc_match_s;
        limit_s      = (cycles_run_r == (max_cycles_r - CYCLE_WIDTH'(1)));
        dump_last_s  = (state_r == ST_DUMP) && (dump_idx_r == LAST_IDX);
        dump_hs_s    = (state_r == ST_DUMP) && dump_ready;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (beat_s) begin
                    state_next_s = load_last ? ST_IDLE : (overflow_s ? ST_DONE : ST_LOAD);
                end else if (start_s) begin
                    state_next_s = (max_cycles == {CYCLE_WIDTH{1'b0}}) ? ST_DUMP : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (beat_s) begin
                    state_next_s = load_last ? ST_IDLE : (overflow_s ? ST_DONE : ST_LOAD);
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_RUN:  state_next_s = (pc_match_s || limit_s) ? ST_DUMP : ST_RUN;
            ST_DUMP: state_next_s = (dump_hs_s && dump_last_s) ? ST_DONE : ST_DUMP;
            ST_DONE: state_next_s = clear ? ST_IDLE : ST_DONE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Write counter, latched run parameters, cycle count, halt cause and dump index
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr_r    <= {PC_WIDTH{1'b0}};
            max_cycles_r <= {CYCLE_WIDTH{1'b0}};
            cycles_run_r <= {CYCLE_WIDTH{1'b0}};
            halt_pc_r    <= {PC_WIDTH{1'b0}};
            halt_pc_en_r <= 1'b0;
            halt_cause_r <= 2'b00;
            dump_idx_r   <= {REG_ADDR_WIDTH{1'b0}};
        end else begin
            if (beat_s) begin
                wr_addr_r <= cur_addr_s + PC_WIDTH'(1);
            end
            if (overflow_s) begin
                halt_cause_r <= 2'b11;
            end
            if (start_s) begin
                max_cycles_r <= max_cycles;
                halt_pc_r    <= halt_pc;
                halt_pc_en_r <= halt_pc_en;
                cycles_run_r <= {CYCLE_WIDTH{1'b0}};
                halt_cause_r <= (max_cycles == {CYCLE_WIDTH{1'b0}}) ? 2'b01 : 2'b00;
            end
            // A PC match blocks the edge entirely, so it also takes precedence over the budget
            if (state_r == ST_RUN) begin
                if (pc_match_s) begin
                    halt_cause_r <= 2'b10;
                end else begin
                    cycles_run_r <= cycles_run_r + CYCLE_WIDTH'(1);
                    if (limit_s) begin
                        halt_cause_r <= 2'b01;
                    end
                end
            end
            if (dump_hs_s) begin
                dump_idx_r <= dump_last_s ? {REG_ADDR_WIDTH{1'b0}} : (dump_idx_r + REG_ADDR_WIDTH'(1));
            end
        end
    end

    // Output decode
    always_comb begin
        load_ready  = load_ready_s;
        imem_we     = beat_s;
        imem_addr   = cur_addr_s;
        imem_wdata  = load_data;
        cpu_run     = run_s;
        cpu_rst_n   = (state_r == ST_RUN) || (state_r == ST_DUMP) || (state_r == ST_DONE);
        reg_rd_addr = dump_idx_r;
        dump_valid  = (state_r == ST_DUMP);
        dump_data   = reg_rd_data;
        dump_idx    = dump_idx_r;
        dump_last   = dump_last_s;
        busy        = (state_r == ST_LOAD) || (state_r == ST_RUN) || (state_r == ST_DUMP);
        done        = (state_r == ST_DONE);
        halt_cause  = halt_cause_r;
        cycles_run  = cycles_run_r;
    end

endmodule

// File: tb/tb_mips_run_controller.sv
// Bench for mips_run_controller: a stub core executes nop/addi/jal from the loaded program,
// and a program-level model predicts run length, halt cause and the dumped register file.
module tb_mips_run_controller;
    localparam int PW = 10;

    logic        clock = 1'b0;
    logic        reset_n, load_valid, load_last, start, clear, halt_pc_en, dump_ready;
    logic [31:0] load_data;
    logic [15:0] max_cycles;
    logic [9:0]  halt_pc, cpu_pc;
    logic        load_ready, imem_we, cpu_run, cpu_rst_n, dump_valid, dump_last, busy, done;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [3:0]  reg_rd_addr, dump_idx;
    logic [15:0] reg_rd_data, dump_data, cycles_run;
    logic [1:0]  halt_cause;

    logic        d2_load_valid, d2_load_last, d2_load_ready, d2_imem_we, d2_cpu_run, d2_cpu_rst_n;
    logic        d2_dump_valid, d2_dump_last, d2_busy, d2_done, d2_zero;
    logic [31:0] d2_load_data, d2_imem_wdata;
    logic [2:0]  d2_imem_addr, d2_pc_zero;
    logic [3:0]  d2_reg_rd_addr, d2_dump_idx;
    logic [15:0] d2_dump_data, d2_cycles_run, d2_data_zero;
    logic [1:0]  d2_halt_cause;

    always #5 clock = ~clock;

    mips_run_controller dut (
        .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .start(start), .clear(clear), .max_cycles(max_cycles),
        .halt_pc(halt_pc), .halt_pc_en(halt_pc_en), .cpu_pc(cpu_pc), .cpu_run(cpu_run),
        .cpu_rst_n(cpu_rst_n), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data), .dump_idx(dump_idx),
        .dump_last(dump_last), .busy(busy), .done(done), .halt_cause(halt_cause), .cycles_run(cycles_run)
    );

    mips_run_controller #(.PC_WIDTH(3)) dut2 (
        .clock(clock), .reset_n(reset_n), .load_valid(d2_load_valid), .load_ready(d2_load_ready),
        .load_data(d2_load_data), .load_last(d2_load_last), .imem_we(d2_imem_we), .imem_addr(d2_imem_addr),
        .imem_wdata(d2_imem_wdata), .start(d2_zero), .clear(d2_zero), .max_cycles(d2_data_zero),
        .halt_pc(d2_pc_zero), .halt_pc_en(d2_zero), .cpu_pc(d2_pc_zero), .cpu_run(d2_cpu_run),
        .cpu_rst_n(d2_cpu_rst_n), .reg_rd_addr(d2_reg_rd_addr), .reg_rd_data(d2_data_zero),
        .dump_valid(d2_dump_valid), .dump_ready(d2_zero), .dump_data(d2_dump_data), .dump_idx(d2_dump_idx),
        .dump_last(d2_dump_last), .busy(d2_busy), .done(d2_done), .halt_cause(d2_halt_cause),
        .cycles_run(d2_cycles_run)
    );

    // Stub core: nop / addi rt,rs,imm / jal target (r15 <- pc+1), word-addressed PC
    logic [31:0] imem [0:1023];
    logic [15:0] regs [0:15];
    logic [9:0]  core_pc;
    logic [31:0] ir;
    assign ir          = imem[core_pc];
    assign cpu_pc      = core_pc;
    assign reg_rd_data = regs[reg_rd_addr];

    always @(posedge clock) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
        if (!cpu_rst_n) begin
            core_pc <= 10'd0;
            for (int i = 0; i < 16; i++) regs[i] <= 16'd0;
        end else if (cpu_run) begin
            case (ir[31:26])
                6'h03: begin
                    regs[15] <= 16'(core_pc) + 16'd1;
                    core_pc  <= ir[9:0];
                end
                6'h08: begin
                    if (ir[19:16] != 4'd0) regs[ir[19:16]] <= regs[ir[24:21]] + ir[15:0];
                    core_pc <= core_pc + 10'd1;
                end
                default: core_pc <= core_pc + 10'd1;
            endcase
        end
    end

    // Reference model state
    logic [31:0] prog [0:1023];
    logic [15:0] m_regs [0:15];
    int          exp_cycles;
    logic [1:0]  exp_cause;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        exp_we;
        logic [9:0]  exp_addr;
        logic        exp_busy;
    } load_vec_t;
    load_vec_t lv [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Executes the program from pc 0 with all registers zero, counting executed instructions
    task automatic model_run(input int maxc, input bit en, input int hp);
        int          pc = 0;
        int          n = 0;
        logic [31:0] ins;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;
        exp_cause = 2'b01;
        while (n < maxc) begin
            if (en && pc == hp) begin
                exp_cause = 2'b10;
                break;
            end
            ins = prog[pc];
            if (ins[31:26] == 6'h03) begin
                m_regs[15] = 16'(pc + 1);
                pc = int'(ins[9:0]);
            end else begin
                if (ins[31:26] == 6'h08 && ins[19:16] != 4'd0)
                    m_regs[ins[19:16]] = m_regs[ins[24:21]] + ins[15:0];
                pc = (pc + 1) % 1024;
            end
            n++;
        end
        exp_cycles = n;
    endtask

    task automatic load_words(input int n);
        int i = 0;
        while (i < n) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = prog[i];
            load_last  = (i == n - 1);
            #1;
            chk("load_beat", {imem_we, imem_addr, imem_wdata}, {load_valid, 10'(i), prog[i]});
            if (load_valid) i++;
            @(negedge clock);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        chk("load_end_idle", {busy, load_ready, cpu_rst_n}, 3'b010);
    endtask

    // mode: 0 ready always, 1 ready toggling 1/0, 2 random; stop_at < 16 resets mid-dump
    task automatic run_and_dump(input int maxc, input bit en, input int hp, input int mode, input int stop_at);
        int runs = 0;
        int guard = 0;
        int k = 0;
        int cyc = 0;
        model_run(maxc, en, hp);
        max_cycles = 16'(maxc);
        halt_pc    = 10'(hp);
        halt_pc_en = en;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        chk("run_core_released", cpu_rst_n, 1'b1);
        if (maxc == 0) chk("zero_budget_dump", {dump_valid, cpu_run}, 2'b10);
        while (busy && !dump_valid && guard < 300) begin
            if (cpu_run) runs++;
            guard++;
            @(negedge clock);
            #1;
        end
        chk("run_in_bound", guard < 300, 1'b1);
        chk("run_cycles_high", runs, exp_cycles);
        chk("run_result", {cycles_run, halt_cause}, {16'(exp_cycles), exp_cause});
        while (k < stop_at && cyc < 300) begin
            case (mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = (cyc % 2 == 0);
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("dump_beat", {dump_valid, cpu_run, dump_idx, dump_last, dump_data},
                {1'b1, 1'b0, 4'(k), k == 15, m_regs[k]});
            if (dump_ready) k++;
            cyc++;
            @(negedge clock);
        end
        dump_ready = 1'b0;
        #1;
        if (stop_at < 16) begin
            chk("pre_reset_idx", {dump_valid, dump_idx}, {1'b1, 4'(stop_at)});
            reset_n    = 1'b0;
            load_valid = 1'b1;
            #1;
            chk("async_reset_outputs",
                {imem_we, imem_addr, cpu_run, cpu_rst_n, dump_valid, dump_last, dump_idx,
                 busy, done, halt_cause, cycles_run, load_ready},
                {1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 16'd0, 1'b1});
            load_valid = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
            #1;
        end else begin
            if (mode == 1) chk("toggle_dump_cycles", cyc, 31);
            chk("done_state", {done, busy, dump_valid, cpu_rst_n, halt_cause, cycles_run},
                {1'b1, 1'b0, 1'b0, 1'b1, exp_cause, 16'(exp_cycles)});
            clear = 1'b1;
            @(negedge clock);
            clear = 1'b0;
            #1;
            chk("clear_to_idle", {done, busy, cpu_rst_n, load_ready}, 4'b0001);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            imem[i] = 32'd0;
            prog[i] = 32'd0;
        end
        reset_n = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 32'd0; start = 1'b0;
        clear = 1'b0; halt_pc_en = 1'b0; halt_pc = 10'd0; max_cycles = 16'd0; dump_ready = 1'b0;
        d2_load_valid = 1'b0; d2_load_last = 1'b0; d2_load_data = 32'd0;
        d2_zero = 1'b0; d2_pc_zero = 3'd0; d2_data_zero = 16'd0;
        #1;
        chk("reset_values",
            {imem_we, imem_addr, cpu_run, cpu_rst_n, dump_valid, dump_last, dump_idx,
             busy, done, halt_cause, cycles_run, load_ready},
            {1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 16'd0, 1'b1});
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Load beat has priority over start; single-beat program stays in IDLE
        load_valid = 1'b1; load_last = 1'b1; load_data = 32'd0; start = 1'b1; max_cycles = 16'd5;
        #1;
        chk("prio_write", {imem_we, imem_addr}, {1'b1, 10'd0});
        @(negedge clock);
        load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
        #1;
        chk("prio_start_ignored", {busy, cpu_rst_n, load_ready, cpu_run}, 4'b0010);

        lv[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 10'd0, 1'b0};
        lv[1] = '{1'b1, 32'h20010005, 1'b0, 1'b1, 10'd0, 1'b1};
        lv[2] = '{1'b0, 32'h12345678, 1'b0, 1'b0, 10'd1, 1'b1};
        lv[3] = '{1'b1, 32'h0C000003, 1'b0, 1'b1, 10'd1, 1'b1};
        lv[4] = '{1'b1, 32'h00000000, 1'b0, 1'b1, 10'd2, 1'b1};
        lv[5] = '{1'b1, 32'h03E00008, 1'b1, 1'b1, 10'd3, 1'b0};
        lv[6] = '{1'b0, 32'h0000FFFF, 1'b0, 1'b0, 10'd0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            load_valid = lv[i].valid; load_data = lv[i].data; load_last = lv[i].last;
            #1;
            chk("vec_write", {imem_we, imem_addr, imem_wdata}, {lv[i].exp_we, lv[i].exp_addr, lv[i].data});
            if (lv[i].valid) prog[lv[i].exp_addr] = lv[i].data;
            @(negedge clock);
            #1;
            chk("vec_busy", {busy, load_ready}, {lv[i].exp_busy, 1'b1});
        end
        load_valid = 1'b0; load_last = 1'b0;

        // Budget-limited run of the 4-word program
        run_and_dump(10, 1'b0, 0, 0, 16);
        chk("budget_result", {cycles_run, halt_cause}, {16'd10, 2'b01});

        // jal program halting at pc 5 after four executed instructions
        prog[0] = 32'h20010005; prog[1] = 32'h00000000; prog[2] = 32'h0C000004; prog[3] = 32'h00000000;
        prog[4] = 32'h20220001; prog[5] = 32'h03E00008; prog[6] = 32'h00000000; prog[7] = 32'h00000000;
        load_words(8);
        run_and_dump(20, 1'b1, 5, 0, 16);
        chk("pc_halt_result", {cycles_run, halt_cause}, {16'd4, 2'b10});
        run_and_dump(20, 1'b1, 5, 1, 16);
        run_and_dump(0, 1'b1, 5, 0, 16);
        chk("zero_budget_result", {cycles_run, halt_cause}, {16'd0, 2'b01});

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 2))
                    0:       prog[i] = 32'h00000000;
                    1:       prog[i] = {6'h08, 1'b0, 4'($urandom_range(0, 15)), 1'b0,
                                        4'($urandom_range(0, 15)), 16'($urandom)};
                    default: prog[i] = {6'h03, 16'h0000, 10'($urandom_range(0, 7))};
                endcase
            end
            prog[7] = {6'h03, 16'h0000, 10'($urandom_range(0, 7))};
            load_words(8);
            run_and_dump($urandom_range(0, 40), 1'($urandom_range(0, 1)), $urandom_range(0, 7), 2, 16);
        end

        // Reset while the dump is presenting index 7
        load_words(8);
        run_and_dump(30, 1'b0, 0, 0, 7);

        // Narrow instruction memory: eight beats without last overflow into DONE
        for (int i = 0; i < 8; i++) begin
            d2_load_valid = 1'b1; d2_load_data = 32'(i) * 32'd3 + 32'd7; d2_load_last = 1'b0;
            #1;
            chk("ovf_write", {d2_imem_we, d2_imem_addr, d2_imem_wdata}, {1'b1, 3'(i), 32'(i) * 32'd3 + 32'd7});
            @(negedge clock);
        end
        d2_load_valid = 1'b0;
        #1;
        chk("ovf_done", {d2_done, d2_busy, d2_halt_cause, d2_load_ready, d2_imem_we}, {1'b1, 1'b0, 2'b11, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
- Hardware sequencer that takes over the bench-level load/run/dump flow around the single-cycle MIPS core.
- Streams a program into instruction memory, releases the core for a bounded number of cycles, and optionally halts early on a PC match (for example, a jal target).
- Freezes the core and streams the register file out over a valid/ready port.
- Parametrised in instruction, PC, data and register-file widths; sits between the external host and single_cycle_mips.

Parameters:
INST_WIDTH, 32, instruction word width
PC_WIDTH, 10, instruction memory address width
DATA_WIDTH, 16, register data width
REG_ADDR_WIDTH, 4, register index width
NUM_REGS, 16, registers dumped (≤ 2^REG_ADDR_WIDTH)
CYCLE_WIDTH, 16, run-cycle counter width

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
load_valid  in  1  program beat valid
load_ready  out  1  program beat accepted when high
load_data  in  INST_WIDTH  instruction word
load_last  in  1  final program beat
imem_we  out  1  instruction memory write strobe
imem_addr  out  PC_WIDTH  instruction memory write address
imem_wdata  out  INST_WIDTH  instruction memory write data
start  in  1  single-cycle pulse to begin run (IDLE only)
clear  in  1  returns DONE to IDLE
max_cycles  in  CYCLE_WIDTH  run budget, latched on start
halt_pc  in  PC_WIDTH  halt address, latched on start
halt_pc_en  in  1  enables PC-match halt, latched on start
cpu_pc  in  PC_WIDTH  core's current PC
cpu_run  out  1  core clock enable
cpu_rst_n  out  1  core reset, active low
reg_rd_addr  out  REG_ADDR_WIDTH  register-file read index
reg_rd_data  in  DATA_WIDTH  combinational register read data
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump beat accepted
dump_data  out  DATA_WIDTH  register value
dump_idx  out  REG_ADDR_WIDTH  register index of beat
dump_last  out  1  final dump beat
busy  out  1  high in LOAD/RUN/DUMP
done  out  1  high in DONE
halt_cause  out  2  00 none, 01 cycle limit, 10 PC match, 11 load overflow
cycles_run  out  CYCLE_WIDTH  cycles with cpu_run high

Behaviour:
- States: IDLE, LOAD, RUN, DUMP, DONE.
- Reset (async, reset_n=0) forces IDLE immediately. Reset values: imem_we=0, imem_addr=0, cpu_run=0, cpu_rst_n=0, dump_valid=0, dump_last=0, dump_idx=0, busy=0, done=0, halt_cause=00, cycles_run=0, load_ready=1. Reset mid-operation abandons everything; imem_we drops without waiting for a clock.
- load_ready=1 in IDLE and LOAD only.
- Load handshake: beat = load_valid&load_ready. imem_we=beat combinationally (zero latency), imem_addr=write counter, imem_wdata=load_data. The counter increments per beat and resets to 0 on entry from IDLE.
- IDLE→LOAD on a beat without load_last. A beat with load_last returns to IDLE, including a single-beat program.
- Overflow: a beat at address 2^PC_WIDTH−1 without load_last is still written; state→DONE, halt_cause=11.
- IDLE + start (and no load beat): latch max_cycles/halt_pc/halt_pc_en, clear cycles_run and halt_cause.
  - If the latched max_cycles=0: →DUMP, halt_cause=01.
  - Otherwise: →RUN.
- A load beat has priority over start in the same cycle; that start is ignored. start is ignored outside IDLE.
- cpu_rst_n=0 in IDLE/LOAD, 1 in RUN/DUMP/DONE. Core state is preserved for the dump.
- RUN: cpu_run = !(halt_pc_en_l && cpu_pc==halt_pc_l), combinational. cycles_run increments each edge where cpu_run=1.
  - PC match: the instruction at halt_pc is NOT executed; →DUMP, halt_cause=10.
  - Otherwise, when cycles_run reaches max_cycles−1 with cpu_run=1: that edge increments to max_cycles, →DUMP, halt_cause=01.
  - If both occur in the same cycle, the PC match wins.
- DUMP: cpu_run=0, dump_valid=1, reg_rd_addr=dump_idx, dump_data=reg_rd_data (combinational). dump_last=(dump_idx==NUM_REGS−1).
  - On dump_valid&dump_ready, dump_idx increments. The last handshake →DONE, dump_idx→0.
  - dump_ready low holds dump_idx, dump_data and dump_last stable.
- DONE: done=1, halt_cause and cycles_run held; clear→IDLE (clear is ignored elsewhere).
- busy=1 in LOAD/RUN/DUMP.

Test Plan:
- Load 4 words 0x20010005, 0x0C000003, 0x00000000, 0x03E00008 with load_last on the 4th → imem_we 4 consecutive cycles at addr 0..3 with matching data; state back to IDLE, busy=0.
- start, max_cycles=10, halt_pc_en=0 → cpu_rst_n rises, cpu_run high exactly 10 cycles, cycles_run=10, halt_cause=01; 16 dump beats idx 0..15, dump_last only on idx 15, done=1.
- jal program, halt_pc_en=1, halt_pc=5, core PC reaches 5 on run cycle 5 → cpu_run low that cycle, cycles_run=4, halt_cause=10; dumped r15 equals the return address written by jal.
- dump_ready toggling 1/0 each cycle → each idx presented until accepted, 16 beats over 31 cycles, dump_data equals the register-file contents.
- max_cycles=0 start → cpu_run never high, cycles_run=0, immediately DUMP, halt_cause=01; then clear → IDLE, cpu_rst_n=0.
- PC_WIDTH=3: 8 beats without load_last → 8 writes at addr 0..7, DONE with halt_cause=11, load_ready=0. Separately, reset_n low mid-DUMP at idx 7 → all outputs at reset values in the same cycle, IDLE.
